// File: rtl/mem_stage_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_v2_if
// Description : E->M->W handshake bundle plus data-SRAM response and
//               M->D forwarding signals for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_v2_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              W_allowin;
    logic              M_allowin;
    logic              EM_valid;
    logic [DATA_W-1:0] em_pc;
    logic [DATA_W-1:0] em_alu_result;
    logic              em_gr_we;
    logic [REG_AW-1:0] em_dest;
    logic              em_mem_req;
    logic [2:0]        em_ld_op;
    logic [DATA_W-1:0] data_rdata;
    logic              data_data_ok;
    logic              MW_valid;
    logic [DATA_W-1:0] mw_pc;
    logic [DATA_W-1:0] mw_result;
    logic              mw_gr_we;
    logic [REG_AW-1:0] mw_dest;
    logic [REG_AW-1:0] md_for_dest;
    logic [DATA_W-1:0] md_for_data;
    logic              md_for_stall;

    // Environment side: upstream E, downstream W and the data SRAM
    modport master (
        output W_allowin, EM_valid, em_pc, em_alu_result, em_gr_we, em_dest,
               em_mem_req, em_ld_op, data_rdata, data_data_ok,
        input  M_allowin, MW_valid, mw_pc, mw_result, mw_gr_we, mw_dest,
               md_for_dest, md_for_data, md_for_stall
    );

    // The memory stage itself
    modport slave (
        input  W_allowin, EM_valid, em_pc, em_alu_result, em_gr_we, em_dest,
               em_mem_req, em_ld_op, data_rdata, data_data_ok,
        output M_allowin, MW_valid, mw_pc, mw_result, mw_gr_we, mw_dest,
               md_for_dest, md_for_data, md_for_stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_v2.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_v2
// Description : Memory-access pipeline stage. Waits for variable-latency
//               data-SRAM responses, buffers them while W is stalled,
//               extracts/extends load data and drives forwarding/stall
//               information back to Decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_v2 #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_stage_v2_if.slave    bus
);
    localparam int OFS_W = $clog2(DATA_W / 8);

    localparam logic [2:0] c_OP_LB  = 3'd1;
    localparam logic [2:0] c_OP_LBU = 3'd2;
    localparam logic [2:0] c_OP_LH  = 3'd3;
    localparam logic [2:0] c_OP_LHU = 3'd4;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_alu;
    logic              r_gr_we;
    logic [REG_AW-1:0] r_dest;
    logic              r_mem_req;
    logic [2:0]        r_ld_op;
    logic              r_got;
    logic [DATA_W-1:0] r_rbuf;

    logic              w_ready_go;
    logic              w_allowin;
    logic              w_leave;
    logic [DATA_W-1:0] w_raw;
    logic [OFS_W-1:0]  w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_final;

    // A memory instruction may leave once its response is buffered or arriving now
    assign w_ready_go = !r_mem_req || r_got || bus.data_data_ok;
    assign w_allowin  = !r_valid || (w_ready_go && bus.W_allowin);
    assign w_leave    = r_valid && w_ready_go && bus.W_allowin;

    // Pipeline register: valid follows E whenever we accept, fields only on real capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_alu     <= '0;
            r_gr_we   <= 1'b0;
            r_dest    <= '0;
            r_mem_req <= 1'b0;
            r_ld_op   <= '0;
        end else begin
            if (w_allowin) begin
                r_valid <= bus.EM_valid;
            end
            if (bus.EM_valid && w_allowin) begin
                r_pc      <= bus.em_pc;
                r_alu     <= bus.em_alu_result;
                r_gr_we   <= bus.em_gr_we;
                r_dest    <= bus.em_dest;
                r_mem_req <= bus.em_mem_req;
                r_ld_op   <= bus.em_ld_op;
            end
        end
    end

    // Response buffer: hold a strobe that cannot be consumed this cycle; drop strays
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_got  <= 1'b0;
            r_rbuf <= '0;
        end else if (w_leave) begin
            r_got <= 1'b0;
        end else if (bus.data_data_ok && r_valid && r_mem_req && !r_got) begin
            r_got  <= 1'b1;
            r_rbuf <= bus.data_rdata;
        end
    end

    // Lane selection; the halfword ignores offset bit 0 since misalignment traps upstream
    assign w_raw  = r_got ? r_rbuf : bus.data_rdata;
    assign w_off  = r_alu[OFS_W-1:0];
    assign w_byte = w_raw[{w_off, 3'b000} +: 8];
    assign w_half = w_raw[{w_off[OFS_W-1:1], 4'b0000} +: 16];

    // Load extension by type; unknown encodings behave as a full-width load
    always_comb begin
        w_ext = w_raw;
        case (r_ld_op)
            c_OP_LB:  w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_OP_LBU: w_ext = {{(DATA_W-8){1'b0}}, w_byte};
            c_OP_LH:  w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
            c_OP_LHU: w_ext = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_ext = w_raw;
        endcase
    end

    assign w_final = r_mem_req ? w_ext : r_alu;

    assign bus.M_allowin    = w_allowin;
    assign bus.MW_valid     = r_valid && w_ready_go;
    assign bus.mw_pc        = r_pc;
    assign bus.mw_result    = w_final;
    assign bus.mw_gr_we     = r_gr_we;
    assign bus.mw_dest      = r_dest;
    assign bus.md_for_dest  = r_dest & {REG_AW{r_valid && r_gr_we}};
    assign bus.md_for_data  = w_final;
    assign bus.md_for_stall = r_valid && r_mem_req && !r_got && !bus.data_data_ok;

endmodule
`default_nettype wire

// File: doc/mem_stage_v2.md
# mem_stage_v2

Parametrised memory-access pipeline stage between Execute (E) and Writeback (W). It accepts variable-latency data-SRAM responses: the stage stalls until `data_data_ok` arrives, and it buffers the response if W is stalled. It extracts and extends byte/halfword/word load data, and it drives forwarding and load-use stall information back to Decode. One register stage, with the same valid/allowin handshake as the rest of the pipeline.

## Interface
- DATA_W, 32, datapath/register width; legal values 32 or 64
- REG_AW, 5, register-file address width
- OFS_W, log2(DATA_W/8), byte-offset bits used for lane selection (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- W_allowin  in  1  W stage can accept
- M_allowin  out  1  this stage can accept
- EM_valid  in  1  E presents an instruction
- em_pc  in  DATA_W  instruction PC
- em_alu_result  in  DATA_W  ALU result or load address
- em_gr_we  in  1  writes register file
- em_dest  in  REG_AW  destination register
- em_mem_req  in  1  E issued a data-SRAM request that will return `data_data_ok`
- em_ld_op  in  3  load type: 0 = LW (full DATA_W), 1 = LB, 2 = LBU, 3 = LH, 4 = LHU; 5–7 are treated as LW
- data_rdata  in  DATA_W  SRAM read data, valid with `data_data_ok`
- data_data_ok  in  1  one-cycle response strobe
- MW_valid  out  1  valid to W
- mw_pc  out  DATA_W  PC to W
- mw_result  out  DATA_W  final result to W
- mw_gr_we  out  1  register write enable to W
- mw_dest  out  REG_AW  destination register to W
- md_for_dest  out  REG_AW  forwarding destination; 0 when not writing
- md_for_data  out  DATA_W  forwarding value
- md_for_stall  out  1  M holds a load whose data is not yet available

## Operation
- Capture: when `EM_valid && M_allowin`, latch all `em_*` fields.
  - `M_valid <= EM_valid` whenever `M_allowin`.
  - Fields are held otherwise.
- Response state: flag `got`, plus a DATA_W buffer `rbuf`.
  - On `data_data_ok && M_valid && mem_req_M && !got && !(M_ready_go && W_allowin)`, set `got = 1` and `rbuf = data_rdata`.
  - Clear `got` when the instruction leaves (`M_valid && M_ready_go && W_allowin`).
  - `data_data_ok` with no pending request (`!M_valid`, `!mem_req_M`, or `got`) is ignored.
- Ready: `M_ready_go = !mem_req_M || got || data_data_ok`.
  - `M_allowin = !M_valid || (M_ready_go && W_allowin)`.
  - `MW_valid = M_valid && M_ready_go`.
- Raw data: `raw = got ? rbuf : data_rdata`.
- Load extraction, with `off = alu_result_M[OFS_W-1:0]`:
  - LB/LBU select `raw[8*off +: 8]`.
  - LH/LHU select `raw[16*off[OFS_W-1:1] +: 16]`; `off[0]` is ignored, because misalignment is trapped upstream.
  - LB/LH sign-extend to DATA_W; LBU/LHU zero-extend; LW passes `raw` unchanged.
- Result: `final = mem_req_M ? extracted : alu_result_M`. Drives both `mw_result` and `md_for_data`.
- Forwarding:
  - `md_for_dest = dest_M & {REG_AW{M_valid && gr_we_M}}`.
  - `md_for_stall = M_valid && mem_req_M && !got && !data_data_ok`.
- Stores: set `mem_req_M = 1` and `gr_we = 0`. They wait for `data_data_ok` like loads; the result is unused.

## Timing
- Reset (async, with `rst` high): `M_valid = 0`, `got = 0`, `rbuf = 0`, all latched fields 0. Consequently:
  - `MW_valid = 0` and `md_for_stall = 0`.
  - `md_for_dest = 0` and `M_allowin = 1`.
  - `mw_result = 0`.
- Reset mid-wait: the pending request is abandoned. A late `data_data_ok` after reset is ignored, because `M_valid = 0`.
- Non-memory instruction: MW_valid rises in the cycle after capture. Throughput is 1 per cycle while W_allowin holds.
- Memory instruction:
  - If `data_data_ok` arrives in cycle N with W_allowin high, MW_valid is high in N and `mw_result` is combinational from `data_rdata`, with zero added latency.
  - If `data_data_ok` arrives while W is stalled, `rbuf` holds the data. MW_valid stays high, from `rbuf`, until W_allowin.
- `data_data_ok` in the same cycle as capture of a new instruction belongs to the old instruction. The bench never does this while M is waiting, since `M_allowin = 0` then.
- MW outputs stay stable while `MW_valid && !W_allowin`.

## Test plan
1. Reset asserted mid-stream → all outputs go to reset values immediately, without waiting for clk. Release → `M_allowin = 1`.
2. ALU op, dest = 5, result 0x1234, W_allowin = 1 → next cycle: MW_valid = 1, mw_result = 0x1234, md_for_dest = 5, md_for_stall = 0.
3. LB, addr 0x...02, `data_data_ok` 3 cycles after capture with rdata 0x80FF0011:
   - md_for_stall = 1 for 2 cycles.
   - Then MW_valid = 1 with mw_result = 0xFFFFFFFF (byte 0xFF sign-extended).
   - LBU on the same data → 0x000000FF.
4. LH, addr offset 2, rdata 0x8001_7FFF → 0xFFFF8001. LHU → 0x00008001. LW → 0x80017FFF.
5. Load `data_data_ok` with W_allowin = 0 for 4 cycles, with `data_rdata` changing to garbage after the strobe → MW_valid held at 1, mw_result stable from the buffer. Exits on W_allowin; `got` clears.
6. DATA_W = 64, LB with offset 7, rdata byte 7 = 0x7F → result 0x000000000000007F. Spurious `data_data_ok` while idle → no state change.
